// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage: PC, next-PC select, imem handshake, IF/ID register
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_IFWrite,
  input  logic        Z,
  input  logic        J,
  input  logic        JR,
  input  logic [31:0] BranchAddr,
  input  logic [31:0] JumpAddr,
  input  logic [31:0] JrAddr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] PC_if,
  output logic [31:0] Instruction_id,
  output logic [31:0] NextPC_id,
  output logic        FetchBusy
);

  // FETCH: request outstanding at PC. HOLD: word captured during a stall,
  // no request. DRAIN: a redirect arrived mid-request; finish the stale
  // request (address must stay stable) and throw its data away.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] instr_q, instr_nxt;
  logic [31:0] npc_q, npc_nxt;
  logic [31:0] hold_q, hold_nxt;
  logic [31:0] pend_q, pend_nxt;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        redir;
  logic        req;
  logic        busy;

  assign pc_plus4 = pc + 32'd4;
  // Decode's redirect is only meaningful when the pipeline is allowed to move.
  assign redir    = PC_IFWrite & (J | JR | Z);

  // Redirect target: jump beats jr beats branch.
  always_comb begin
    target = BranchAddr;
    if (J)
      target = JumpAddr;
    else if (JR)
      target = JrAddr;
  end

  // Next-state, next-register values and handshake outputs.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr_q;
    npc_nxt   = npc_q;
    hold_nxt  = hold_q;
    pend_nxt  = pend_q;
    req       = 1'b0;
    busy      = 1'b1;
    case (state)
      FETCH: begin
        req = 1'b1;
        if (imem_ack) begin
          if (PC_IFWrite) begin
            if (redir) begin
              instr_nxt = NOP_INSTR;
              npc_nxt   = 32'h0;
              pc_nxt    = target;
            end else begin
              instr_nxt = imem_rdata;
              npc_nxt   = pc_plus4;
              pc_nxt    = pc_plus4;
              busy      = 1'b0;
            end
          end else begin
            hold_nxt  = imem_rdata;
            state_nxt = HOLD;
          end
        end else if (PC_IFWrite) begin
          instr_nxt = NOP_INSTR;
          npc_nxt   = 32'h0;
          if (redir) begin
            pend_nxt  = target;
            state_nxt = DRAIN;
          end
        end
      end
      HOLD: begin
        if (PC_IFWrite) begin
          if (redir) begin
            instr_nxt = NOP_INSTR;
            npc_nxt   = 32'h0;
            pc_nxt    = target;
          end else begin
            instr_nxt = hold_q;
            npc_nxt   = pc_plus4;
            pc_nxt    = pc_plus4;
            busy      = 1'b0;
          end
          state_nxt = FETCH;
        end
      end
      DRAIN: begin
        req = 1'b1;
        if (PC_IFWrite) begin
          instr_nxt = NOP_INSTR;
          npc_nxt   = 32'h0;
        end
        if (imem_ack) begin
          pc_nxt    = pend_q;
          state_nxt = FETCH;
        end
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  // All stage state; reset abandons any in-flight request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      instr_q <= NOP_INSTR;
      npc_q   <= 32'h0;
      hold_q  <= 32'h0;
      pend_q  <= 32'h0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      instr_q <= instr_nxt;
      npc_q   <= npc_nxt;
      hold_q  <= hold_nxt;
      pend_q  <= pend_nxt;
    end
  end

  assign imem_req       = req & ~reset;
  assign imem_addr      = pc;
  assign PC_if          = pc;
  assign Instruction_id = instr_q;
  assign NextPC_id      = npc_q;
  assign FetchBusy      = busy;

endmodule
